// File: rtl/sample_averager_if.sv
// Sample stream bus between the upstream stage, the averager and its consumer.
interface sample_averager_if;
  logic [31:0] data_in;
  logic        data_in_valid;
  logic        ce;
  logic        clear;
  logic [31:0] data_out;
  logic        data_out_valid;
  logic        busy;
  logic [15:0] block_cnt;

  // Drives samples and control, observes the averaged result.
  modport master (
    output data_in, data_in_valid, ce, clear,
    input  data_out, data_out_valid, busy, block_cnt
  );

  // The averager itself.
  modport slave (
    input  data_in, data_in_valid, ce, clear,
    output data_out, data_out_valid, busy, block_cnt
  );
endinterface

// File: rtl/sample_averager.sv
// Block averager: sums 2^LOG2_N signed samples and emits their mean
// (floor or round-half-up) as a registered single-cycle pulse.
//
// state   | meaning
// --------+---------------------------------------------
// S_IDLE  | no partial block held, count=0, acc=0
// S_ACCUM | partial block held, count>=1
module sample_averager #(
  parameter int LOG2_N = 2,
  parameter int ROUND  = 0
) (
  input  logic             clk,
  input  logic             rst,
  sample_averager_if.slave bus
);

  localparam int AW = 32 + LOG2_N;

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_ACCUM = 1'b1;

  // Count value of the last sample in a block (N-1).
  localparam logic [LOG2_N-1:0] CNT_LAST = '1;

  // Half an LSB of the result, added before the shift when rounding.
  localparam logic [AW:0] RND = (ROUND != 0) ? ((AW+1)'(1) << (LOG2_N-1)) : '0;

  logic [0:0]        state_q, state_d;
  logic [AW-1:0]     acc_q,   acc_d;
  logic [LOG2_N-1:0] cnt_q,   cnt_d;
  logic [31:0]       dout_q,  dout_d;
  logic              vld_q,   vld_d;
  logic [15:0]       bcnt_q,  bcnt_d;

  logic              accept;
  logic              last;
  logic [AW-1:0]     acc_add;
  logic [AW:0]       sum_rnd;

  // Datapath: sign-extended accumulate, optional rounding, arithmetic shift.
  always_comb begin
    accept  = bus.ce & bus.data_in_valid & ~bus.clear;
    last    = accept && (cnt_q == CNT_LAST);
    acc_add = acc_q + {{LOG2_N{bus.data_in[31]}}, bus.data_in};
    // One extra bit so the rounding constant can never wrap the sum.
    sum_rnd = {acc_add[AW-1], acc_add} + RND;
  end

  // Next-state: clear wins over a sample; the Nth sample emits and restarts.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    dout_d  = dout_q;
    vld_d   = 1'b0;
    bcnt_d  = bcnt_q;
    if (bus.clear) begin
      state_d = S_IDLE;
      acc_d   = '0;
      cnt_d   = '0;
    end else if (accept) begin
      if (last) begin
        state_d = S_IDLE;
        acc_d   = '0;
        cnt_d   = '0;
        vld_d   = 1'b1;
        dout_d  = 32'($signed(sum_rnd) >>> LOG2_N);
        bcnt_d  = bcnt_q + 16'd1;
      end else begin
        state_d = S_ACCUM;
        acc_d   = acc_add;
        cnt_d   = cnt_q + 1'b1;
      end
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      dout_q  <= '0;
      vld_q   <= 1'b0;
      bcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      dout_q  <= dout_d;
      vld_q   <= vld_d;
      bcnt_q  <= bcnt_d;
    end
  end

  assign bus.data_out       = dout_q;
  assign bus.data_out_valid = vld_q;
  assign bus.busy           = (state_q == S_ACCUM);
  assign bus.block_cnt      = bcnt_q;

endmodule
